dw_window_feeder: RTL



---
 rtl/dw_window_feeder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dw_window_feeder.sv
// Streaming 3x3 window generator for the depthwise-conv calc unit.
// Takes one FP32 plane in raster order and emits one 9-word window per valid stride-1 position.
module dw_window_feeder #(
    parameter int unsigned MAX_W = 112,
    parameter int unsigned DIM_W = 8
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    input  logic [31:0]      pix_in,
    input  logic             pix_in_vld,
    output logic             pix_in_rdy,
    output logic [32*9-1:0]  win_out,
    output logic             win_out_vld,
    output logic             new_start,
    output logic             frame_done,
    output logic             cfg_err
);

    localparam int unsigned IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             r_state;
    logic               r_rdy;
    logic [DIM_W-1:0]   r_w;
    logic [DIM_W-1:0]   r_h;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic               r_err;
    logic               r_vld;
    logic               r_done;
    logic [32*9-1:0]    r_win;
    logic [31:0]        r_sr [9];
    logic [31:0]        r_lb0 [MAX_W];
    logic [31:0]        r_lb1 [MAX_W];

    logic               w_acc;
    logic               w_start;
    logic               w_in_frame;
    logic [DIM_W-1:0]   w_cur_w;
    logic [DIM_W-1:0]   w_cur_h;
    logic               w_geo_err;
    logic               w_err;
    logic               w_col_end;
    logic               w_last;
    logic               w_emit;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_sr_nxt [9];
    logic [32*9-1:0]    w_win_nxt;

    always_comb begin
        w_acc      = pix_in_vld & r_rdy;
        w_start    = (r_state == StIdle) & w_acc & frame_start;
        w_in_frame = w_start | ((r_state == StRun) & w_acc);
        // The frame-start pixel uses the live geometry since it is latched on the same edge.
        w_cur_w    = w_start ? img_w : r_w;
        w_cur_h    = w_start ? img_h : r_h;
        w_geo_err  = (img_w < DIM_W'(3)) | (img_h < DIM_W'(3)) | (32'(img_w) > MAX_W);
        w_err      = w_start ? w_geo_err : r_err;
        w_col_end  = (r_col == w_cur_w - DIM_W'(1));
        w_last     = (w_cur_w == '0) | (w_cur_h == '0)
                   | (w_col_end & (r_row == w_cur_h - DIM_W'(1)));
        w_emit     = w_in_frame & ~w_err & (r_row >= DIM_W'(2)) & (r_col >= DIM_W'(2));
        w_idx      = IDX_W'(r_col);
        for (int r = 0; r < 3; r++) begin
            w_sr_nxt[3*r]   = r_sr[3*r+1];
            w_sr_nxt[3*r+1] = r_sr[3*r+2];
        end
        w_sr_nxt[2] = r_lb1[w_idx];
        w_sr_nxt[5] = r_lb0[w_idx];
        w_sr_nxt[8] = pix_in;
        w_win_nxt   = '0;
        for (int k = 0; k < 9; k++) begin
            w_win_nxt[32*k +: 32] = w_sr_nxt[k];
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_rdy   <= 1'b0;
            r_w     <= '0;
            r_h     <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_err   <= 1'b0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
            r_win   <= '0;
            for (int k = 0; k < 9; k++) begin
                r_sr[k] <= '0;
            end
        end else begin
            r_vld  <= w_emit;
            r_done <= 1'b0;
            if (w_emit) begin
                r_win <= w_win_nxt;
            end
            if (w_start) begin
                r_w   <= img_w;
                r_h   <= img_h;
                r_err <= w_geo_err;
            end
            if (w_in_frame) begin
                for (int k = 0; k < 9; k++) begin
                    r_sr[k] <= w_sr_nxt[k];
                end
                if (w_last) begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= StDone;
                    r_rdy   <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= StRun;
                    r_rdy   <= 1'b1;
                    if (w_col_end) begin
                        r_col <= '0;
                        r_row <= r_row + DIM_W'(1);
                    end else begin
                        r_col <= r_col + DIM_W'(1);
                    end
                end
            end else if (r_state == StDone) begin
                r_state <= StIdle;
                r_rdy   <= 1'b1;
            end else begin
                r_rdy <= 1'b1;
            end
        end
    end

    // Line buffers: old contents are read into the window on the same edge they are overwritten.
    always_ff @(posedge clk_100M) begin
        if (w_in_frame && !w_err) begin
            r_lb1[w_idx] <= r_lb0[w_idx];
            r_lb0[w_idx] <= pix_in;
        end
    end

    assign pix_in_rdy  = r_rdy;
    assign win_out     = r_win;
    assign win_out_vld = r_vld;
    assign new_start   = r_vld;
    assign frame_done  = r_done;
    assign cfg_err     = r_err;

endmodule
